sseg_scan_controller: RTL and testbench
=======================================

# sseg_scan_controller

Time-multiplexing scheduler for the board's 8-digit common-anode seven-segment display. It shares one hex-to-seven-segment decode path across eight digits and drives one anode at a time. Each digit slot has a dark gap to prevent ghosting. The block sits between the calculator core, which presents a 32-bit value plus decimal-point and blank masks, and the display pins. Input values are double-buffered so a frame never shows a torn value.

## Interface
Parameters:
- DWELL, 100000, clock cycles a digit is lit per slot (≥1; 1 ms at 100 MHz)
- GAP, 16, clock cycles all anodes are off before each digit (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- hex_in  in  32  eight nibbles; hex_in[4i+3:4i] is digit i, where digit 0 is rightmost
- dp_in  in  8  decimal-point request per digit, active-high
- blank_in  in  8  per-digit blank request, active-high
- lz_en  in  1  leading-zero suppression enable, sampled live
- load  in  1  one-cycle strobe that captures hex_in/dp_in/blank_in into the pending buffer
- an  out  8  anode enables, active-low, registered
- sseg  out  8  segments, active-low, registered; sseg[6:0] = g..a, sseg[7] = dp
- frame_done  out  1  one-cycle pulse at each frame wrap, registered

## Operation
- Registers:
  - pending {hex, dp, blank} buffer
  - active {hex, dp, blank} buffer
  - digit index d (3 bits)
  - cycle counter sized for max(DWELL, GAP)
  - state
- FSM states:
  - GAP: an = 8'hFF, sseg = 8'hFF. After GAP cycles, go to DRIVE with the same d.
  - DRIVE: lights digit d. After DWELL cycles, go to GAP with d+1 mod 8.
- Wrap: the transition DRIVE(d=7) → GAP(d=0).
  - frame_done = 1 for that one cycle.
  - active ← pending.
  - If load is asserted in the wrap cycle, active takes the values on hex_in/dp_in/blank_in directly (load bypasses pending).
- load outside the wrap cycle updates pending only. The displayed value is unchanged until the next wrap. Repeated loads: the last one before the wrap wins.
- Digit d is suppressed (an stays 8'hFF during DRIVE, sseg = 8'hFF) when either condition holds:
  - active.blank[d] = 1, or
  - lz_en = 1, d > 0, and for every k ≥ d: active.hex nibble k = 0 and active.dp[k] = 0.
- Digit 0 is never zero-suppressed.
- Otherwise, during DRIVE(d):
  - an = ~(8'b1 << d).
  - sseg[6:0] = standard active-low decode of active nibble d: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
  - sseg[7] = ~active.dp[d].
- an never has more than one bit low in any cycle.

## Timing
- Reset (asynchronous assertion, synchronous-release-safe):
  - state = GAP, d = 0, counter = 0
  - an = 8'hFF, sseg = 8'hFF, frame_done = 0
  - pending/active hex = 0, dp = 0, blank = 8'hFF, so nothing is lit until the first load reaches active
- Slot period is GAP + DWELL cycles; frame period is 8 × (GAP + DWELL).
- Outputs are registered. Values for a state appear on the clock edge that enters the state and hold for its full duration.
- frame_done is high in the first cycle of GAP(d=0) after a wrap. It is not asserted after reset.
- Latency from load to display: the value becomes active at the next wrap and is first lit GAP cycles later, at digit 0.
- Reset mid-frame: outputs go to 8'hFF immediately (asynchronously). Scanning restarts at GAP(d=0) with blank = all ones. Pending data is lost.
- lz_en and the suppression decision are evaluated in the cycle before entering DRIVE. A change mid-slot takes effect at the next slot.

## Test plan
- Reset: hold reset_n = 0 → an = 8'hFF, sseg = 8'hFF, frame_done = 0. After release with no load, run 2 frames → an stays 8'hFF throughout.
- Scan order (DWELL = 4, GAP = 2): load hex_in = 32'h7654_3210, blank = 0, dp = 0 before the first wrap → from the second frame:
  - digit 0 lit 4 cycles with an = 8'hFE, sseg = 8'hC0
  - then 2 dark cycles
  - then an = 8'hFD, sseg = 8'hF9
  - … through an = 8'h7F, sseg = 8'hF8
  - frame_done pulses every 48 cycles
- Double buffer: load 32'h1111_1111 mid-frame while 32'h2222_2222 is active → remaining digits of that frame still show sseg = 8'hA4. The next frame shows 8'hF9.
- Load on wrap cycle: assert load exactly when frame_done is high, with hex = 32'hFFFF_FFFF → digit 0 of the frame starting then shows sseg = 8'h8E.
- Masks and suppression: hex = 32'h0000_00A5, dp = 8'h01, lz_en = 1 →
  - digit 0 shows sseg = 8'h12 (dp on)
  - digit 1 shows 8'h88
  - digits 2–7 keep an = 8'hFF
  - with lz_en = 0, digits 2–7 show 8'hC0
  - adding blank = 8'h02 darkens digit 1
- Reset mid-operation: assert reset_n = 0 during DRIVE(d = 5) → an = 8'hFF in the same cycle. After release, first lit slot is digit 0 only after a new load and wrap.

Source files
------------

// File: rtl/sseg_scan_controller_if.sv
// Bundle between the calculator core and the seven-segment scan controller.
//   hex_in     : eight nibbles, nibble i is digit i (digit 0 rightmost)
//   dp_in      : per-digit decimal point request, active-high
//   blank_in   : per-digit blank request, active-high
//   lz_en      : leading-zero suppression enable (sampled live)
//   load       : one-cycle strobe capturing hex_in/dp_in/blank_in
//   an         : anode enables, active-low
//   sseg       : segments, active-low; [6:0] = g..a, [7] = dp
//   frame_done : one-cycle pulse at each frame wrap
// The master modport is the core/bench side, the slave modport is the controller.
interface sseg_scan_controller_if;
  logic [31:0] hex_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic        lz_en;
  logic        load;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        frame_done;

  modport master (
    output hex_in, dp_in, blank_in, lz_en, load,
    input  an, sseg, frame_done
  );

  modport slave (
    input  hex_in, dp_in, blank_in, lz_en, load,
    output an, sseg, frame_done
  );
endinterface

// File: rtl/sseg_scan_controller.sv
// Time-multiplexed scan of an 8-digit common-anode seven-segment display.
// Each digit slot is GAP dark cycles followed by DWELL lit cycles; digits
// are scanned 0..7. Input data is double-buffered: load writes the pending
// buffer, and pending moves to the active buffer at each frame wrap.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of sseg_scan_controller_if (data in, an/sseg/frame_done out)
module sseg_scan_controller #(
  parameter int unsigned DWELL = 100000,
  parameter int unsigned GAP   = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  sseg_scan_controller_if.slave  bus
);

  localparam int unsigned MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic {S_GAP, S_DRIVE} state_t;

  state_t        state, state_n;
  logic [2:0]    d, d_n;
  logic [CW-1:0] cnt, cnt_n;

  logic [31:0] pend_hex, act_hex, act_hex_n;
  logic [7:0]  pend_dp, act_dp, act_dp_n;
  logic [7:0]  pend_blank, act_blank, act_blank_n;

  logic [7:0] an_q, an_n;
  logic [7:0] sseg_q, sseg_n;
  logic       fd_q, fd_n;

  logic [7:0] nz;
  logic [3:0] nib;
  logic       supp;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  // The buffer swap is performed in the cycle frame_done is high (first
  // cycle of GAP(0)), so a load strobed alongside frame_done lands in the
  // active buffer directly. Decoding looks at the post-swap value so a
  // GAP of one cycle still shows the new frame at digit 0.
  always_comb begin
    act_hex_n   = act_hex;
    act_dp_n    = act_dp;
    act_blank_n = act_blank;
    if (fd_q) begin
      if (bus.load) begin
        act_hex_n   = bus.hex_in;
        act_dp_n    = bus.dp_in;
        act_blank_n = bus.blank_in;
      end else begin
        act_hex_n   = pend_hex;
        act_dp_n    = pend_dp;
        act_blank_n = pend_blank;
      end
    end
  end

  // Digit d is a leading zero when it and every digit above it has a zero
  // nibble and no decimal point.
  always_comb begin
    nz = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      nz[k] = (act_hex_n[4*k +: 4] != 4'h0) | act_dp_n[k];
    end
    nib  = act_hex_n[{d, 2'b00} +: 4];
    supp = act_blank_n[d] |
           (bus.lz_en & (d != 3'd0) & ((nz >> d) == 8'h00));
  end

  always_comb begin
    state_n = state;
    d_n     = d;
    cnt_n   = cnt + 1'b1;
    an_n    = an_q;
    sseg_n  = sseg_q;
    fd_n    = 1'b0;
    case (state)
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          state_n = S_DRIVE;
          cnt_n   = '0;
          if (supp) begin
            an_n   = '1;
            sseg_n = '1;
          end else begin
            an_n   = ~(8'b1 << d);
            sseg_n = {~act_dp_n[d], seg7(nib)};
          end
        end
      end
      S_DRIVE: begin
        if (cnt == CW'(DWELL - 1)) begin
          state_n = S_GAP;
          cnt_n   = '0;
          d_n     = d + 3'd1;
          an_n    = '1;
          sseg_n  = '1;
          fd_n    = (d == 3'd7);
        end
      end
      default: begin
        state_n = S_GAP;
        cnt_n   = '0;
        an_n    = '1;
        sseg_n  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_GAP;
      d          <= '0;
      cnt        <= '0;
      an_q       <= '1;
      sseg_q     <= '1;
      fd_q       <= 1'b0;
      pend_hex   <= '0;
      pend_dp    <= '0;
      pend_blank <= '1;
      act_hex    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
    end else begin
      state     <= state_n;
      d         <= d_n;
      cnt       <= cnt_n;
      an_q      <= an_n;
      sseg_q    <= sseg_n;
      fd_q      <= fd_n;
      act_hex   <= act_hex_n;
      act_dp    <= act_dp_n;
      act_blank <= act_blank_n;
      if (bus.load) begin
        pend_hex   <= bus.hex_in;
        pend_dp    <= bus.dp_in;
        pend_blank <= bus.blank_in;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_controller.sv
// Directed bench for sseg_scan_controller with DWELL=4, GAP=2 (48-cycle frame).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sseg_scan_controller;
  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  sseg_scan_controller_if bus_if ();

  sseg_scan_controller #(.DWELL(4), .GAP(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to a falling edge where frame_done is high (bounded).
  task automatic wait_fd(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!found) begin
        if (bus_if.frame_done === 1'b1) found = 1'b1;
        else @(negedge clk);
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Starting at the frame_done cycle (c=0), check all 48 cycles of a frame.
  // segs[8d+:8] is the hand-computed segment pattern of digit d, lit marks
  // which digits light. An optional load is strobed at cycle load_cyc.
  task automatic check_frame(input string tag, input logic [63:0] segs,
                             input logic [7:0] lit, input logic lz,
                             input int load_cyc, input logic [31:0] lh,
                             input logic [7:0] ldp, input logic [7:0] lbl);
    int d;
    logic on;
    logic [7:0] exp_an, exp_seg;
    for (int c = 0; c < 48; c++) begin
      if (c == 0) bus_if.lz_en = lz;
      if (c == load_cyc) begin
        bus_if.hex_in   = lh;
        bus_if.dp_in    = ldp;
        bus_if.blank_in = lbl;
        bus_if.load     = 1'b1;
      end else begin
        bus_if.load = 1'b0;
      end
      d  = c / 6;
      on = ((c % 6) >= 2) && lit[d];
      exp_an  = on ? (8'hFF ^ (8'd1 << d)) : 8'hFF;
      exp_seg = on ? segs[8*d +: 8] : 8'hFF;
      chk({tag, "_an"},   {24'd0, bus_if.an},   {24'd0, exp_an});
      chk({tag, "_sseg"}, {24'd0, bus_if.sseg}, {24'd0, exp_seg});
      chk({tag, "_fd"},   {31'd0, bus_if.frame_done}, {31'd0, (c == 0)});
      @(negedge clk);
    end
    bus_if.load = 1'b0;
  endtask

  initial begin
    int first_fd;
    int fd_cnt;
    logic any_lit;

    reset_n         = 1'b0;
    bus_if.hex_in   = '0;
    bus_if.dp_in    = '0;
    bus_if.blank_in = '0;
    bus_if.lz_en    = 1'b0;
    bus_if.load     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an",   {24'd0, bus_if.an},   32'hFF);
    chk("rst_sseg", {24'd0, bus_if.sseg}, 32'hFF);
    chk("rst_fd",   {31'd0, bus_if.frame_done}, 32'd0);

    // Two frames with no load: nothing lights, one wrap at cycle 48.
    reset_n  = 1'b1;
    first_fd = -1;
    fd_cnt   = 0;
    any_lit  = 1'b0;
    for (int k = 0; k < 96; k++) begin
      if (bus_if.an !== 8'hFF) any_lit = 1'b1;
      if (bus_if.frame_done === 1'b1) begin
        fd_cnt++;
        if (first_fd < 0) first_fd = k;
      end
      @(negedge clk);
    end
    chk("idle_dark",   {31'd0, any_lit}, 32'd0);
    chk("idle_fd_pos", first_fd, 32'd48);
    chk("idle_fd_cnt", fd_cnt,   32'd1);

    // Scan order.
    bus_if.hex_in = 32'h7654_3210; bus_if.dp_in = '0; bus_if.blank_in = '0;
    bus_if.load = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    wait_fd("wait_scan");
    check_frame("scan", 64'hF882_9299_B0A4_F9C0, 8'hFF, 1'b0, -1, '0, '0, '0);

    // Double buffer and load-on-wrap.
    check_frame("wrapld2", 64'hA4A4_A4A4_A4A4_A4A4, 8'hFF, 1'b0, 0, 32'h2222_2222, '0, '0);
    check_frame("midld1",  64'hA4A4_A4A4_A4A4_A4A4, 8'hFF, 1'b0, 20, 32'h1111_1111, '0, '0);
    check_frame("show1",   64'hF9F9_F9F9_F9F9_F9F9, 8'hFF, 1'b0, -1, '0, '0, '0);
    check_frame("wrapldF", 64'h8E8E_8E8E_8E8E_8E8E, 8'hFF, 1'b0, 0, 32'hFFFF_FFFF, '0, '0);

    // Masks and leading-zero suppression.
    check_frame("lz_a5",   64'hFFFF_FFFF_FFFF_8812, 8'h03, 1'b1, 0, 32'h0000_00A5, 8'h01, 8'h00);
    check_frame("nolz_a5", 64'hC0C0_C0C0_C0C0_8812, 8'hFF, 1'b0, -1, '0, '0, '0);
    check_frame("blank1",  64'hC0C0_C0C0_C0C0_8812, 8'hFD, 1'b0, 0, 32'h0000_00A5, 8'h01, 8'h02);
    check_frame("lz_zero", 64'hFFFF_FFFF_FFFF_FFC0, 8'h01, 1'b1, 0, 32'h0000_0000, 8'h00, 8'h00);
    check_frame("lz_mid0", 64'hFFFF_FFFF_FFF9_C0C0, 8'h07, 1'b1, 0, 32'h0000_0100, 8'h00, 8'h00);
    check_frame("lz_dp6",  64'hFF40_C0C0_C0C0_C0C0, 8'h7F, 1'b1, 0, 32'h0000_0000, 8'h40, 8'h00);

    // Reset during DRIVE(d=5), with data sitting in pending.
    for (int c = 0; c < 33; c++) begin
      if (c == 20) begin
        bus_if.hex_in = 32'h8888_8888; bus_if.dp_in = '0; bus_if.blank_in = '0;
        bus_if.load = 1'b1;
      end else begin
        bus_if.load = 1'b0;
      end
      @(negedge clk);
    end
    chk("pre_rst_an", {24'd0, bus_if.an}, 32'hDF);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_an",   {24'd0, bus_if.an},   32'hFF);
    chk("mid_rst_sseg", {24'd0, bus_if.sseg}, 32'hFF);
    chk("mid_rst_fd",   {31'd0, bus_if.frame_done}, 32'd0);
    bus_if.lz_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    any_lit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.an !== 8'hFF) any_lit = 1'b1;
      @(negedge clk);
    end
    chk("post_rst_dark", {31'd0, any_lit}, 32'd0);

    bus_if.hex_in = 32'h7654_3210; bus_if.dp_in = '0; bus_if.blank_in = '0;
    bus_if.load = 1'b1;
    @(negedge clk);
    bus_if.load = 1'b0;
    wait_fd("wait_rescan");
    check_frame("rescan", 64'hF882_9299_B0A4_F9C0, 8'hFF, 1'b0, -1, '0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
